// File: rtl/timer_ctrl_pkg.sv
// Shared types and constants for the timer_ctrl15 sequencing controller.
package timer_ctrl_pkg;

   localparam int CNT_W_DEF = 15;
   localparam int ST_W      = 3;

   typedef enum logic [ST_W-1:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_RUN  = 3'd2,
      ST_HOLD = 3'd3,
      ST_DONE = 3'd4
   } state_t;

endpackage

// File: rtl/timer_ctrl15_edge_det.sv
// Rising-edge detector for a level control input, with a registered history.
module edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic sig,
   output logic rise
);

   logic was_low;

   // Cleared history means "not yet seen low", so a level held through reset never fires.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) was_low <= 1'b0;
      else        was_low <= ~sig;
   end

   assign rise = sig & was_low;

endmodule

// File: rtl/timer_ctrl15.sv
// Start/stop/pause sequencer driving a loadable up/down counter.
// Define TIMER_CTRL_TICKCNT_EN to add the run_ticks strobe counter output.
module timer_ctrl15
   import timer_ctrl_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int AUTO_RELOAD = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic             tick,
   input  logic             mode_up,
   input  logic [CNT_W-1:0] target,
   input  logic [CNT_W-1:0] cnt_q,
   input  logic             cnt_utc,
   input  logic             cnt_dtc,
   output logic [CNT_W-1:0] cnt_din,
   output logic             cnt_ld,
   output logic             cnt_up,
   output logic             cnt_dw,
   output logic             busy,
   output logic             done,
   output logic             expired,
   output logic [ST_W-1:0]  state
`ifdef TIMER_CTRL_TICKCNT_EN
   ,
   output logic [15:0]      run_ticks
`endif
);

   state_t           cur_state, nxt_state;
   logic             start_rise;
   logic             mode_q;
   logic [CNT_W-1:0] target_q;
   logic             terminal;
   logic             was_done;

   edge_det u_start_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .sig   (start),
      .rise  (start_rise)
   );

   assign terminal = mode_q ? ((cnt_q == target_q) | cnt_utc) : cnt_dtc;

   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      nxt_state = cur_state;
      cnt_ld    = 1'b0;
      cnt_din   = '0;
      cnt_up    = 1'b0;
      cnt_dw    = 1'b0;
      case (cur_state)
         ST_IDLE: ;
         ST_LOAD: begin
            nxt_state = ST_RUN;
            cnt_ld    = 1'b1;
            cnt_din   = mode_q ? '0 : target_q;
         end
         ST_RUN: begin
            if (terminal)   nxt_state = ST_DONE;
            else if (pause) nxt_state = ST_HOLD;
            else begin
               cnt_up = tick & mode_q;
               cnt_dw = tick & ~mode_q;
            end
         end
         ST_HOLD: if (!pause) nxt_state = ST_RUN;
         ST_DONE: if (AUTO_RELOAD != 0) nxt_state = ST_LOAD;
         default: nxt_state = ST_IDLE;
      endcase
      // stop outranks everything and silences all strobes; a start edge beats any count strobe.
      if (stop) begin
         nxt_state = ST_IDLE;
         cnt_ld    = 1'b0;
         cnt_din   = '0;
         cnt_up    = 1'b0;
         cnt_dw    = 1'b0;
      end else if (start_rise) begin
         nxt_state = ST_LOAD;
         cnt_up    = 1'b0;
         cnt_dw    = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_state <= ST_IDLE;
         mode_q    <= 1'b0;
         target_q  <= '0;
         was_done  <= 1'b0;
      end else begin
         cur_state <= nxt_state;
         was_done  <= (cur_state == ST_DONE);
         if (!stop && start_rise) begin
            mode_q   <= mode_up;
            target_q <= target;
         end
      end
   end

   assign busy    = (cur_state == ST_LOAD) | (cur_state == ST_RUN) | (cur_state == ST_HOLD);
   assign expired = (cur_state == ST_DONE);
   assign done    = expired & ~was_done;
   assign state   = cur_state;

`ifdef TIMER_CTRL_TICKCNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                        run_ticks <= '0;
      else if (cur_state == ST_LOAD)                     run_ticks <= '0;
      else if ((cnt_up | cnt_dw) && run_ticks != 16'hFFFF) run_ticks <= run_ticks + 16'd1;
   end
`endif

endmodule

// File: doc/timer_ctrl15.md
Name: timer_ctrl15

Overview:
- Sequencing controller for the team's 15-bit loadable up/down counter (Din/Up/Dw/LD in, Q/UTC/DTC out).
- Turns start/stop/pause controls and a periodic tick enable into load and count strobes, detects terminal count and reports completion.
- Sits between the top-level control FSM and the counter instance, for game timers and countdown displays.

Parameters:
- CNT_W, 15, counter width; must match the attached counter.
- AUTO_RELOAD, 0, when 1 the controller reloads and restarts automatically after reaching terminal count.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level; the rising edge starts or restarts a run.
- stop  in  1  level; forces IDLE.
- pause  in  1  level; suspends counting while high.
- tick  in  1  one-cycle count enable (for example a 4 Hz strobe).
- mode_up  in  1  0 = count down from target to 0; 1 = count up from 0 to target; sampled on the start edge.
- target  in  CNT_W  run length; sampled on the start edge.
- cnt_q  in  CNT_W  counter Q.
- cnt_utc  in  1  counter UTC.
- cnt_dtc  in  1  counter DTC.
- cnt_din  out  CNT_W  counter Din.
- cnt_ld  out  1  counter LD.
- cnt_up  out  1  counter Up.
- cnt_dw  out  1  counter Dw.
- busy  out  1  high in LOAD, RUN and HOLD.
- done  out  1  one-cycle pulse on entry to DONE.
- expired  out  1  high while in DONE.
- state  out  3  current state encoding.

Behaviour:
- Reset: state = IDLE.
  - All outputs are 0, including cnt_din.
  - The captured mode and target registers are 0.
  - The start edge-detector history is cleared, so a start held high through reset does not fire.
- States: IDLE=0, LOAD=1, RUN=2, HOLD=3, DONE=4. All transitions are registered.
- Priority within a cycle: stop > start edge > terminal > pause > tick.
- stop in any state -> IDLE next edge; no strobes are issued in that cycle.
- Start edge in any state other than stop -> LOAD. It captures mode_up and target; a restart mid-run is allowed.
- LOAD (exactly 1 cycle):
  - cnt_ld = 1.
  - cnt_din = target in down mode, 0 in up mode.
  - Next state is RUN, so the first RUN cycle sees the loaded cnt_q.
- RUN, terminal condition:
  - Down mode: cnt_dtc = 1.
  - Up mode: cnt_q == captured target, or cnt_utc = 1.
  - On terminal -> DONE; no count strobe in that cycle, even if tick = 1.
- RUN, otherwise:
  - pause = 1 -> HOLD, with no strobe in that cycle.
  - Else cnt_dw = tick (down mode) or cnt_up = tick (up mode), asserted combinationally in the same cycle as tick.
- HOLD: no strobes; ticks are dropped, not queued. pause = 0 -> RUN.
- DONE:
  - done pulses in the first cycle only; expired stays high.
  - AUTO_RELOAD = 1 -> LOAD next cycle, reusing the captured mode and target.
  - Otherwise remain in DONE until a start edge or stop.
- target = 0: terminal is reached in the first RUN cycle, so done asserts 2 cycles after the start edge is registered.
- Invariants: cnt_up & cnt_dw is never 1; cnt_ld is never high together with cnt_up or cnt_dw; strobes are only asserted in LOAD and RUN.
- Unused encodings 5-7 -> IDLE next edge.

Optional Feature:
- Macro: TIMER_CTRL_TICKCNT_EN.
- Defined: adds output run_ticks[15:0].
  - Cleared in LOAD.
  - Incremented on every issued cnt_up/cnt_dw strobe.
  - Saturates at 0xFFFF; holds its value in HOLD, DONE and IDLE.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package timer_ctrl_pkg holds:
  - CNT_W_DEF = 15.
  - The state typedef with the fixed encodings above.
  - Constant ST_W = 3.
- Sub-module edge_det: registered rising-edge detector on start, with async active-low reset, 1-cycle output pulse.
- The FSM, capture registers and strobe logic live in timer_ctrl15.

Test Plan:
- Down run: target = 5, mode_up = 0, start, tick every 4 cycles.
  - Expect cnt_ld with cnt_din = 5 for 1 cycle, then exactly 5 cnt_dw strobes.
  - Expect done to pulse once when cnt_dtc = 1 and expired to stay high; any tick in the terminal cycle issues no strobe.
- Up run: target = 3, mode_up = 1.
  - Expect cnt_din = 0 on load, then 3 cnt_up strobes, then DONE when cnt_q = 3.
  - target = 0x7FFF ends on cnt_utc.
- Pause: pause high after 2 of 5 strobes, 3 ticks while held.
  - Expect state = HOLD and no strobes; after release, 3 more strobes, then done.
- Stop and restart:
  - stop mid-RUN -> IDLE next edge, busy = 0, strobes 0.
  - A start edge in RUN with target = 9 -> LOAD with cnt_din = 9.
- AUTO_RELOAD = 1 with target = 2:
  - Expect a done pulse every cycle of the repeating sequence LOAD, RUN..., DONE.
  - Assert rst_n low mid-RUN: all outputs 0 immediately; a start held through reset does not launch.
- target = 0 and the macro variant:
  - target = 0 gives done 2 cycles after the registered start edge, with zero strobes.
  - With TIMER_CTRL_TICKCNT_EN, run_ticks = 5 after the down run above.
